// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - register-file write-port arbiter: W-stage writeback plus a
// squashable FIFO of long-latency results, with pending-write lookup for decode.
module rf_wb_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     w_valid,
    output logic                     w_ready,
    input  logic [4:0]               w_addr,
    input  logic [31:0]              w_data,
    input  logic [31:0]              w_pc,
    input  logic [31:0]              w_instr,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [4:0]               s_addr,
    input  logic [31:0]              s_data,
    input  logic [31:0]              s_pc,
    input  logic [31:0]              s_instr,
    output logic                     rf_wr,
    output logic [4:0]               rf_a3,
    output logic [31:0]              rf_wd,
    output logic [31:0]              rf_pc,
    output logic [31:0]              rf_instr,
    input  logic [4:0]               q_a1,
    input  logic [4:0]               q_a2,
    output logic                     q_hit1,
    output logic                     q_hit2,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int GW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [GW-1:0] LIMIT_C = GW'(STARVE_LIMIT);

    logic [4:0]    q_addr  [DEPTH];
    logic [31:0]   q_data  [DEPTH];
    logic [31:0]   q_pc    [DEPTH];
    logic [31:0]   q_instr [DEPTH];
    logic [DEPTH-1:0] q_vld;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [GW-1:0] age;

    logic w_xfer;
    logic w_wr;
    logic s_push;
    logic pop;

    assign w_ready = (age < LIMIT_C);
    assign s_ready = (count < DEPTH_C);
    assign w_xfer  = w_valid & w_ready;
    assign w_wr    = w_xfer & (w_addr != 5'd0);
    // A secondary result racing a primary write to the same register is older, so it is dropped.
    assign s_push  = s_valid & s_ready & (s_addr != 5'd0) & ~(w_wr & (s_addr == w_addr));
    assign pop     = ~w_wr & (count != '0);

    // Valid bits are cleared on pop, so a set bit always marks a live queued entry.
    always_comb begin
        q_hit1 = 1'b0;
        q_hit2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (q_vld[i] && q_addr[i] == q_a1 && q_a1 != 5'd0) q_hit1 = 1'b1;
            if (q_vld[i] && q_addr[i] == q_a2 && q_a2 != 5'd0) q_hit2 = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (s_push) begin
            q_addr[wr_ptr]  <= s_addr;
            q_data[wr_ptr]  <= s_data;
            q_pc[wr_ptr]    <= s_pc;
            q_instr[wr_ptr] <= s_instr;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_vld  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            age    <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_wr && q_addr[i] == w_addr) q_vld[i] <= 1'b0;
            end
            if (pop) begin
                q_vld[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + AW'(1);
            end
            if (s_push) begin
                q_vld[wr_ptr] <= 1'b1;
                wr_ptr        <= wr_ptr + AW'(1);
            end
            case ({s_push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (count == '0 || pop) age <= '0;
            else if (age < LIMIT_C) age <= age + GW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf_wr    <= 1'b0;
            rf_a3    <= '0;
            rf_wd    <= '0;
            rf_pc    <= '0;
            rf_instr <= '0;
        end else if (w_wr) begin
            rf_wr    <= 1'b1;
            rf_a3    <= w_addr;
            rf_wd    <= w_data;
            rf_pc    <= w_pc;
            rf_instr <= w_instr;
        end else if (pop && q_vld[rd_ptr]) begin
            rf_wr    <= 1'b1;
            rf_a3    <= q_addr[rd_ptr];
            rf_wd    <= q_data[rd_ptr];
            rf_pc    <= q_pc[rd_ptr];
            rf_instr <= q_instr[rd_ptr];
        end else begin
            rf_wr    <= 1'b0;
        end
    end
endmodule
